// File: rtl/usb_test_pkg.sv
// Shared types and constants for the USB FIFO-bridge stream tester.
package usb_test_pkg;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeIncr  = 2'd1,
        ModeConst = 2'd2,
        ModeWalk  = 2'd3
    } tx_mode_e;

    typedef enum logic [1:0] {
        GenIdle,
        GenSend,
        GenGap
    } gen_state_e;

    typedef enum logic {
        ChkHunt,
        ChkTrack
    } chk_state_e;

    localparam int unsigned LedHoldDefault = 32'd50000000;

endpackage

// File: rtl/usb_stream_checker.sv
// RX sequence checker: locks onto an incrementing stream, counts beats and
// mismatches, and stretches each mismatch into a visible error indication.
module usb_stream_checker
    import usb_test_pkg::*;
#(
    parameter int unsigned RXW      = 8,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned LED_HOLD = LedHoldDefault
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [RXW-1:0]   rx_data,
    output logic             err_led,
    output logic [CNT_W-1:0] rx_beats,
    output logic [CNT_W-1:0] err_cnt,
    output logic             locked
);
    localparam int unsigned HoldW = (LED_HOLD > 1) ? $clog2(LED_HOLD + 1) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(LED_HOLD);

    chk_state_e       state_q, state_d;
    logic [RXW-1:0]   expect_q, expect_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] rx_beats_q, rx_beats_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             rx_ready_q;
    logic             locked_q, locked_d;
    logic             err_led_q, err_led_d;
    logic             beat, mismatch;

    assign beat     = rx_valid & rx_ready_q;
    assign mismatch = beat && (state_q == ChkTrack) && (rx_data != expect_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ChkHunt;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ChkHunt:  if (beat) state_d = ChkTrack;
            ChkTrack: state_d = ChkTrack;
        endcase
    end

    always_comb begin
        locked_d   = (state_d == ChkTrack);
        expect_d   = expect_q;
        hold_d     = hold_q;
        rx_beats_d = rx_beats_q;
        err_cnt_d  = err_cnt_q;
        if (hold_q != '0) hold_d = hold_q - HoldW'(1);
        if (beat) begin
            // A match means rx_data == expect_q, so every case advances from rx_data.
            expect_d   = rx_data + RXW'(1);
            rx_beats_d = rx_beats_q + CNT_W'(1);
        end
        if (mismatch) begin
            hold_d = HoldLoad;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        err_led_d = (hold_d != '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            expect_q   <= '0;
            hold_q     <= '0;
            rx_beats_q <= '0;
            err_cnt_q  <= '0;
            rx_ready_q <= 1'b0;
            locked_q   <= 1'b0;
            err_led_q  <= 1'b0;
        end else begin
            expect_q   <= expect_d;
            hold_q     <= hold_d;
            rx_beats_q <= rx_beats_d;
            err_cnt_q  <= err_cnt_d;
            rx_ready_q <= 1'b1;
            locked_q   <= locked_d;
            err_led_q  <= err_led_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign locked   = locked_q;
    assign err_led  = err_led_q;
    assign rx_beats = rx_beats_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: rtl/usb_stream_tester.sv
// USB FIFO-bridge stream tester: bursty pattern generator on TX plus the
// RX sequence checker, with accepted-beat statistics on both sides.
module usb_stream_tester
    import usb_test_pkg::*;
#(
    parameter int unsigned TX_DEXP  = 3,
    parameter int unsigned RX_DEXP  = 0,
    parameter int unsigned LED_HOLD = LedHoldDefault,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              tx_mode,
    input  logic [15:0]             burst_len,
    input  logic [15:0]             gap_len,
    input  logic [(8<<TX_DEXP)-1:0] const_pat,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [(8<<TX_DEXP)-1:0] tx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [(8<<RX_DEXP)-1:0] rx_data,
    output logic                    err_led,
    output logic [CNT_W-1:0]        tx_beats,
    output logic [CNT_W-1:0]        rx_beats,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    locked
);
    localparam int unsigned TXW = 8 << TX_DEXP;
    localparam int unsigned RXW = 8 << RX_DEXP;

    gen_state_e       state_q, state_d;
    tx_mode_e         mode_q, mode_d, mode_in;
    logic [TXW-1:0]   data_q, data_d;
    logic [15:0]      beat_q, beat_d;
    logic [15:0]      gap_q, gap_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] tx_beats_q;
    logic             accept, burst_done;
    logic [16:0]      beat_inc;

    function automatic logic [TXW-1:0] seed_word(tx_mode_e m, logic [TXW-1:0] pat);
        case (m)
            ModeConst: return pat;
            ModeWalk:  return TXW'(1);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [TXW-1:0] next_word(tx_mode_e m, logic [TXW-1:0] d,
                                                 logic [TXW-1:0] pat);
        logic [TXW-1:0] rot;
        rot = {d[TXW-2:0], d[TXW-1]};
        case (m)
            ModeIncr:  return d + TXW'(1);
            ModeConst: return pat;
            ModeWalk:  return (rot == '0) ? TXW'(1) : rot;
            default:   return d;
        endcase
    endfunction

    assign mode_in    = tx_mode_e'(tx_mode);
    assign accept     = valid_q & tx_ready;
    assign beat_inc   = {1'b0, beat_q} + 17'd1;
    assign burst_done = accept && (burst_len != '0) && (beat_inc >= {1'b0, burst_len});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= GenIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_in == ModeOff) begin
            state_d = GenIdle;
        end else begin
            unique case (state_q)
                GenIdle: state_d = GenSend;
                GenSend: if (burst_done && (gap_len != '0)) state_d = GenGap;
                GenGap:  if (gap_q <= 16'd1) state_d = GenSend;
                default: state_d = GenIdle;
            endcase
        end
    end

    // Mode is latched only at beat boundaries so a pending word never changes under the sink.
    always_comb begin
        valid_d = (state_d == GenSend);
        mode_d  = mode_q;
        data_d  = data_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        unique case (state_q)
            GenIdle: begin
                if (state_d == GenSend) begin
                    mode_d = mode_in;
                    data_d = seed_word(mode_in, const_pat);
                    beat_d = '0;
                end
            end
            GenSend: begin
                if (accept) begin
                    mode_d = mode_in;
                    data_d = (mode_in == mode_q) ? next_word(mode_q, data_q, const_pat)
                                                 : seed_word(mode_in, const_pat);
                    beat_d = burst_done ? '0 : beat_q + 16'd1;
                    gap_d  = gap_len;
                end
            end
            GenGap: begin
                if (gap_q != '0) gap_d = gap_q - 16'd1;
                if ((state_d == GenSend) && (mode_in != mode_q)) begin
                    mode_d = mode_in;
                    data_d = seed_word(mode_in, const_pat);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q     <= ModeOff;
            data_q     <= '0;
            beat_q     <= '0;
            gap_q      <= '0;
            valid_q    <= 1'b0;
            tx_beats_q <= '0;
        end else begin
            mode_q  <= mode_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            if (accept) tx_beats_q <= tx_beats_q + CNT_W'(1);
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = data_q;
    assign tx_beats = tx_beats_q;

    usb_stream_checker #(
        .RXW      (RXW),
        .CNT_W    (CNT_W),
        .LED_HOLD (LED_HOLD)
    ) u_checker (
        .clk      (clk),
        .rstn     (rstn),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .err_led  (err_led),
        .rx_beats (rx_beats),
        .err_cnt  (err_cnt),
        .locked   (locked)
    );

endmodule

// File: doc/usb_stream_tester.md
USB_STREAM_TESTER -- requirements
Module: usb_stream_tester

Interface
REQ-001 Parameter TX_DEXP, default 3: TX beat width TXW = 8<<TX_DEXP bits.
REQ-002 Parameter RX_DEXP, default 0: RX beat width RXW = 8<<RX_DEXP bits.
REQ-003 Parameter LED_HOLD, default 50000000: error-indicator stretch in clk cycles.
REQ-004 Parameter CNT_W, default 32: width of all statistics counters.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 tx_mode  input  2  generator mode: 0 OFF, 1 INCR, 2 CONST, 3 WALK (walking one).
REQ-008 burst_len  input  16  beats per burst; 0 means continuous.
REQ-009 gap_len  input  16  idle cycles between bursts.
REQ-010 const_pat  input  TXW  word sent in CONST mode.
REQ-011 tx_valid / tx_ready / tx_data  output / input / output TXW  generator stream to the FIFO bridge.
REQ-012 rx_valid / rx_ready / rx_data  input / output / input RXW  stream from the FIFO bridge into the checker.
REQ-013 err_led  output  1  high while the hold counter is nonzero.
REQ-014 tx_beats, rx_beats, err_cnt  output  CNT_W each  accepted TX beats, accepted RX beats, RX mismatches.
REQ-015 locked  output  1  checker in TRACK state.

Function
REQ-016 A TX beat completes on tx_valid & tx_ready; an RX beat completes on rx_valid & rx_ready.
REQ-017 rx_ready SHALL be 1 at all times outside reset.
REQ-018 Generator FSM states: IDLE, SEND, GAP. OFF forces IDLE with tx_valid = 0 on the next cycle.
REQ-019 IDLE -> SEND when tx_mode != 0.
REQ-020 In SEND, tx_valid = 1 and tx_data SHALL stay stable until accepted.
REQ-021 In SEND, the beat counter increments per accepted beat. When burst_len != 0 and the count reaches burst_len, the FSM goes to SEND -> GAP, or to SEND -> SEND if gap_len = 0.
REQ-022 In GAP, tx_valid = 0 for exactly gap_len cycles, then GAP -> SEND with the beat counter cleared.
REQ-023 A mode change while in SEND or GAP SHALL take effect only after the current beat is accepted; a change to OFF is the exception and aborts immediately.
REQ-024 INCR: first word 0, then data+1 modulo 2^TXW on each accept.
REQ-025 CONST: tx_data = const_pat, sampled on each accept.
REQ-026 WALK: first word 1, then rotate left by 1 on each accept; after bit TXW-1 the word wraps to 1.
REQ-027 Checker FSM states: HUNT, TRACK.
REQ-028 HUNT: the first RX beat sets expect = rx_data+1 (mod 2^RXW), then HUNT -> TRACK with no error counted.
REQ-029 TRACK: if rx_data != expect, err_cnt increments, the hold counter loads LED_HOLD, and expect = rx_data+1 (resynchronise); otherwise expect increments.
REQ-030 The hold counter decrements toward 0 each cycle; a reload on the same cycle as a decrement wins.
REQ-031 tx_beats and rx_beats count accepted beats. All counters wrap modulo 2^CNT_W, except err_cnt, which saturates at all-ones.
REQ-032 All outputs are registered, and tx_data is available the same cycle tx_valid rises.

Reset
REQ-033 While rstn is low: tx_valid = 0, tx_data = 0, generator in IDLE, checker in HUNT, locked = 0, err_led = 0, and all counters 0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst. After release, INCR restarts at 0 and WALK restarts at 1.
REQ-035 The module performs no reset synchronisation internally; rstn is expected to be released synchronously to clk upstream.

Structure
REQ-036 A shared package usb_test_pkg holds the mode enumeration (OFF, INCR, CONST, WALK), the generator and checker state typedefs, and the default LED_HOLD constant.
REQ-037 The checker is one sub-module, usb_stream_checker, parametrised by RXW, CNT_W and LED_HOLD.
REQ-038 The generator FSM, the pattern logic and the TX counters stay in the top level.

Verification
REQ-039 INCR, TXW=64, burst_len=0, tx_ready=1 for 10 cycles -> tx_data 0..9 on consecutive cycles, tx_beats=10.
REQ-040 INCR, burst_len=4, gap_len=3, tx_ready=1 -> pattern of 4 valid cycles then 3 invalid cycles, and tx_data continues 4,5,6,7 in the second burst.
REQ-041 tx_ready held low for 5 cycles mid-burst -> tx_data unchanged and beat count unchanged.
REQ-042 WALK, TXW=8, 9 accepts -> 01,02,04,...,80,01.
REQ-043 RX bytes 05,06,07,09,0A -> locked after the first beat, err_cnt=1, err_led high for LED_HOLD cycles, no further errors.
REQ-044 rstn pulsed low mid-burst -> tx_valid low within the same cycle, all counters 0, checker back in HUNT.
